// File: rtl/key_sw_conditioner.sv
// Input front end for ctrl_fsm. Synchronises and debounces the raw buttons and switches.
// Each key press becomes one active-low pulse, and keys can optionally auto-repeat while held.
module key_sw_conditioner #(
    parameter int         DB_CYCLES   = 2_000_000,
    parameter int         REPEAT_DLY  = 50_000_000,
    parameter int         REPEAT_PER  = 10_000_000,
    parameter logic [3:0] REPEAT_MASK = 4'b0100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_raw_n,
    input  logic [5:0] sw_raw,
    output logic [3:0] key_pulse_n,
    output logic [3:0] key_level,
    output logic [5:0] sw_db
);

    localparam int NBITS    = 10;
    localparam int DBW      = $clog2(DB_CYCLES + 1);
    localparam int HOLD_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]  DLY_LAST = HW'(REPEAT_DLY - 1);
    localparam logic [HW-1:0]  PER_LAST = HW'(REPEAT_PER - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD_WAIT,
        REPEATING
    } rep_state_t;

    logic [NBITS-1:0] raw_in;
    logic [NBITS-1:0] sync1;
    logic [NBITS-1:0] sync2;
    logic [NBITS-1:0] db_level;
    logic [DBW-1:0]   db_cnt [NBITS];

    logic [3:0]  level_d;
    logic [3:0]  rise;
    logic [3:0]  rep_fire;
    rep_state_t  state    [4];
    rep_state_t  state_nx [4];
    logic [HW-1:0] hold_cnt [4];
    logic [HW-1:0] hold_nx  [4];

    // Keys are inverted so every bit is active-high; reset value 0 means "released".
    assign raw_in = {sw_raw, ~key_raw_n};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            db_level <= '0;
            for (int i = 0; i < NBITS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            for (int i = 0; i < NBITS; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    assign key_level = db_level[3:0];
    assign sw_db     = db_level[9:4];

    // A dropped level forces IDLE before any repeat can fire, so a release never pulses.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rise[i]     = key_level[i] & ~level_d[i];
            rep_fire[i] = 1'b0;
            state_nx[i] = state[i];
            hold_nx[i]  = hold_cnt[i];
            if (!REPEAT_MASK[i] || !key_level[i]) begin
                state_nx[i] = IDLE;
                hold_nx[i]  = '0;
            end else begin
                case (state[i])
                    IDLE: begin
                        if (rise[i]) begin
                            state_nx[i] = HELD_WAIT;
                            hold_nx[i]  = '0;
                        end
                    end
                    HELD_WAIT: begin
                        if (hold_cnt[i] == DLY_LAST) begin
                            rep_fire[i] = 1'b1;
                            state_nx[i] = REPEATING;
                            hold_nx[i]  = '0;
                        end else begin
                            hold_nx[i] = hold_cnt[i] + HW'(1);
                        end
                    end
                    REPEATING: begin
                        if (hold_cnt[i] == PER_LAST) begin
                            rep_fire[i] = 1'b1;
                            hold_nx[i]  = '0;
                        end else begin
                            hold_nx[i] = hold_cnt[i] + HW'(1);
                        end
                    end
                    default: begin
                        state_nx[i] = IDLE;
                        hold_nx[i]  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d     <= '0;
            key_pulse_n <= 4'hF;
            for (int i = 0; i < 4; i++) begin
                state[i]    <= IDLE;
                hold_cnt[i] <= '0;
            end
        end else begin
            level_d     <= key_level;
            key_pulse_n <= ~(rise | rep_fire);
            for (int i = 0; i < 4; i++) begin
                state[i]    <= state_nx[i];
                hold_cnt[i] <= hold_nx[i];
            end
        end
    end

endmodule
